mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DEPTH, 64, valid word count of the shared data memory; MAX_LOCK, 16, maximum consecutive locked grants to one port.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single system clock, rising-edge logic;
  rst_n  in  1  asynchronous, active-low reset;
  req0 / req1  in  1  port 0 (core) / port 1 (aux) request;
  we0 / we1  in  1  write enable of port request;
  a0 / a1  in  32  byte address of port request;
  wd0 / wd1  in  32  write data of port request;
  lock0 / lock1  in  1  port requests to keep ownership for a burst;
  ack0 / ack1  out  1  one-cycle completion pulse;
  err0 / err1  out  1  completion with error, valid only with ack;
  rd0 / rd1  out  32  read data, valid only with ack;
  mem_we  out  1  memory write enable;
  mem_a  out  32  memory byte address;
  mem_wd  out  32  memory write data;
  mem_rd  in  32  memory combinational read data.

Function
REQ-003 Each port SHALL hold req, we, a, wd stable from assertion until its ack; at most one issue per clock cycle.
REQ-004 Issue cycle N: mem_a/mem_wd SHALL be driven combinationally from the granted port; mem_we = granted we AND address valid.
REQ-005 Latency SHALL be one cycle: mem_rd (reads) captured at the rising edge ending cycle N; ack, rd, err asserted during cycle N+1 for exactly one cycle.
REQ-006 A port SHALL NOT be issued in a cycle where its own ack is high (that req is the transaction being completed); the other port MAY be issued in that cycle.
REQ-007 Single eligible requester: it SHALL be granted.
REQ-008 Both eligible: round-robin pointer rr decides; rr SHALL point to the port not granted last; rr reset value = 0.
REQ-009 Lock: if the last-granted port has lock high and is eligible again, it SHALL be granted ahead of rr, up to MAX_LOCK consecutive grants; after MAX_LOCK, ownership SHALL pass to the other port if it requests, and the lock counter SHALL clear.
REQ-010 The lock counter SHALL clear on any grant to the other port, or when the owner deasserts lock.
REQ-011 Address valid SHALL be a[1:0] == 0 and a[31:2] < DEPTH; otherwise: no memory write, rd = 0, err = 1 with ack.
REQ-012 Write transactions SHALL return rd = 0 and err = 0 when valid.
REQ-013 No eligible requester: mem_we SHALL be 0; mem_a and mem_wd SHALL be 0.
REQ-014 Internal state SHALL be: ack_state in {NONE, ACK0, ACK1}, rr, lock_cnt (width clog2(MAX_LOCK+1)), rd_q, err_q; next ack_state = ACKx if port x issued in cycle N, else NONE.
REQ-015 The memory commits a write at the falling edge inside cycle N; the arbiter SHALL keep mem_* stable for the whole of cycle N.

Reset
REQ-016 When rst_n is low, asynchronously: ack0 = ack1 = 0, err0 = err1 = 0, rd0 = rd1 = 0, ack_state = NONE, rr = 0, lock_cnt = 0; mem_we SHALL be forced to 0.
REQ-017 A transaction issued in the cycle reset asserts SHALL be dropped with no ack; requesters SHALL re-request after rst_n returns high.
REQ-018 First issue is permitted in the first cycle with rst_n high.

Verification
REQ-019 Read: memory word 3 = 0xDEADBEEF; req0 with a0 = 0x0C, we0 = 0 -> ack0 next cycle, rd0 = 0xDEADBEEF, err0 = 0.
REQ-020 Contention: req0 and req1 held high after reset -> grants in order 0,1,0,1; one ack per cycle from cycle 2; each port acks every second cycle.
REQ-021 Lock: lock1 and req1 high and req0 high, rr = 1, MAX_LOCK = 4 -> four consecutive port-1 grants, then port 0 granted.
REQ-022 Error: req1 with we1 = 1 and a1 = 0x102 (misaligned), then a1 = 0x100 (index 64) -> mem_we = 0 both times; ack1 with err1 = 1, rd1 = 0.
REQ-023 Write-then-read: port 0 writes 0x12345678 to 0x08; port 1 reads 0x08 in the next issue slot -> rd1 = 0x12345678.
REQ-024 Reset mid-operation: rst_n low during an issue cycle -> no ack; all outputs 0; after release, a pending req0 is issued in the first cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Two-port arbiter in front of a single-ported, combinationally-read data
// memory. Port 0 is the core, port 1 the auxiliary master. At most one
// transaction is issued per clock; the memory is driven combinationally from
// the granted port during the issue cycle, and the completion (ack/rd/err)
// is presented for exactly one cycle in the following cycle.
//
// Arbitration: a port whose own ack is high is not eligible (its request is
// the one completing). A single eligible port wins. When both are eligible a
// round-robin pointer picks the port that was not granted last. A port that
// holds lock keeps ownership for up to MAX_LOCK consecutive grants; while it
// owns the memory the other port is held off, including in the owner's ack
// cycles, so the owner's grants are not interleaved.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/1, we0/1        request and write enable per port
//   a0/1, wd0/1          byte address and write data per port
//   lock0/1              burst ownership request per port
//   ack0/1, err0/1, rd0/1  one-cycle completion, error flag, read data
//   mem_we, mem_a, mem_wd  memory write enable, byte address, write data
//   mem_rd               memory combinational read data
//
// ack_state FSM:
//   state | meaning
//   NONE  | no transaction completing this cycle
//   ACK0  | port 0 transaction issued last cycle completes now
//   ACK1  | port 1 transaction issued last cycle completes now

module mem_arbiter #(
  parameter int DEPTH    = 64,
  parameter int MAX_LOCK = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ACK0 = 2'd1,
    ACK1 = 2'd2
  } ack_state_t;

  ack_state_t    r_state;
  ack_state_t    w_state_nxt;
  logic          r_rr;
  logic          w_rr_nxt;
  logic [CW-1:0] r_lock_cnt;
  logic [CW-1:0] w_lock_cnt_nxt;
  logic [31:0]   r_rd_q;
  logic [31:0]   w_rd_nxt;
  logic          r_err_q;
  logic          w_err_nxt;

  logic          w_owner;
  logic          w_owner_lock;
  logic          w_owner_req;
  logic          w_cnt_max;
  logic          w_hold;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_issue;
  logic          w_gnt;
  logic [31:0]   w_a;
  logic [31:0]   w_wd;
  logic          w_we;
  logic          w_lock_g;
  logic          w_addr_ok;

  // rr points at the port not granted last, so the last-granted port
  // (the lock owner) is simply its complement.
  assign w_owner      = ~r_rr;
  assign w_owner_lock = w_owner ? lock1 : lock0;
  assign w_owner_req  = w_owner ? req1  : req0;
  assign w_cnt_max    = (r_lock_cnt == CW'(MAX_LOCK));

  // Owner holds a live locked run: keep the other port off the memory,
  // also during the owner's own ack cycles.
  assign w_hold = w_owner_lock && w_owner_req &&
                  (r_lock_cnt != '0) && !w_cnt_max;

  // Gating with rst_n drops any issue while reset is asserted, which also
  // forces all mem_* outputs to zero.
  assign w_elig0 = rst_n && req0 && (r_state != ACK0) &&
                   !(w_hold && (w_owner == 1'b1));
  assign w_elig1 = rst_n && req1 && (r_state != ACK1) &&
                   !(w_hold && (w_owner == 1'b0));

  assign w_issue = w_elig0 || w_elig1;
  assign w_gnt   = (w_elig0 && w_elig1) ? r_rr : w_elig1;

  assign w_a      = w_gnt ? a1    : a0;
  assign w_wd     = w_gnt ? wd1   : wd0;
  assign w_we     = w_gnt ? we1   : we0;
  assign w_lock_g = w_gnt ? lock1 : lock0;

  assign w_addr_ok = (w_a[1:0] == 2'b00) &&
                     ({2'b00, w_a[31:2]} < 32'(DEPTH));

  assign mem_a  = w_issue ? w_a  : 32'h0;
  assign mem_wd = w_issue ? w_wd : 32'h0;
  assign mem_we = w_issue && w_we && w_addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= NONE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = NONE;
    w_rr_nxt       = r_rr;
    w_lock_cnt_nxt = r_lock_cnt;
    w_rd_nxt       = 32'h0;
    w_err_nxt      = 1'b0;

    if (!w_owner_lock) begin
      w_lock_cnt_nxt = '0;
    end

    if (w_issue) begin
      w_state_nxt = w_gnt ? ACK1 : ACK0;
      w_rr_nxt    = ~w_gnt;
      w_rd_nxt    = (!w_we && w_addr_ok) ? mem_rd : 32'h0;
      w_err_nxt   = !w_addr_ok;

      // Count consecutive locked grants to the same port. A locked grant
      // that starts a new run (other port, first locked grant, or the
      // owner continuing after an exhausted run with no competitor)
      // counts as the first of that run.
      if (!w_lock_g) begin
        w_lock_cnt_nxt = '0;
      end else if ((w_gnt == w_owner) && (r_lock_cnt != '0) && !w_cnt_max) begin
        w_lock_cnt_nxt = r_lock_cnt + CW'(1);
      end else begin
        w_lock_cnt_nxt = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr       <= 1'b0;
      r_lock_cnt <= '0;
      r_rd_q     <= 32'h0;
      r_err_q    <= 1'b0;
    end else begin
      r_rr       <= w_rr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rd_q     <= w_rd_nxt;
      r_err_q    <= w_err_nxt;
    end
  end

  assign ack0 = (r_state == ACK0);
  assign ack1 = (r_state == ACK1);
  assign rd0  = ack0 ? r_rd_q : 32'h0;
  assign rd1  = ack1 ? r_rd_q : 32'h0;
  assign err0 = ack0 && r_err_q;
  assign err1 = ack1 && r_err_q;

endmodule
